// File: rtl/timer_unit.sv
// timer_unit -- memory-mapped cycle timer on the CPU peripheral bus.
//
// Holds a programmable divider (FRE) and a 32-bit tick counter (TIM). While
// the divider is nonzero the counter advances once every `freq` clock cycles.
// Both registers are readable and writable through the bus bridge.
//
// Ports:
//   clk    in   1   system clock, rising edge
//   rst    in   1   synchronous reset, active low
//   addr   in  32   bus address
//   wen    in   1   write strobe, active high
//   wdata  in  32   write data
//   rdata  out 32   read data, combinational from addr and registered state
//   tick   out  1   one-cycle pulse in the cycle after each counter increment
//   ovf    out  1   one-cycle pulse in the cycle after the counter wraps to 0
module timer_unit #(
  parameter logic [31:0] ADDR_TIM = 32'hFFFF_F020,
  parameter logic [31:0] ADDR_FRE = 32'hFFFF_F024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] addr,
  input  logic        wen,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        tick,
  output logic        ovf
);

  logic [31:0] freq;
  logic [31:0] pre;
  logic [31:0] count;

  logic wr_tim;
  logic wr_fre;
  logic running;
  logic period_end;

  assign wr_tim  = wen && (addr == ADDR_TIM);
  assign wr_fre  = wen && (addr == ADDR_FRE);
  assign running = (freq != 32'h0);
  // freq-1 is only meaningful while running, so the compare is gated.
  assign period_end = running && (pre == freq - 32'h1);

  always_ff @(posedge clk) begin
    if (!rst) begin
      freq  <= 32'h0;
      pre   <= 32'h0;
      count <= 32'h0;
      tick  <= 1'b0;
      ovf   <= 1'b0;
    end else begin
      tick <= 1'b0;
      ovf  <= 1'b0;
      if (wr_fre) begin
        // A new divider restarts the period; no increment this cycle.
        freq <= wdata;
        pre  <= 32'h0;
      end else if (running) begin
        if (period_end) begin
          pre <= 32'h0;
          // A TIM write in the same cycle wins over the increment and
          // suppresses both flags, but the prescaler still wraps.
          if (!wr_tim) begin
            count <= count + 32'h1;
            tick  <= 1'b1;
            ovf   <= (count == 32'hFFFF_FFFF);
          end
        end else begin
          pre <= pre + 32'h1;
        end
      end
      if (wr_tim) begin
        count <= wdata;
      end
    end
  end

  always_comb begin
    rdata = 32'h0;
    if (addr == ADDR_TIM) begin
      rdata = count;
    end else if (addr == ADDR_FRE) begin
      rdata = freq;
    end
  end

endmodule

// File: tb/tb_timer_unit.sv
// Testbench for timer_unit: directed stimulus, a cycle-arithmetic reference
// model checked every cycle, plus hand-computed literal expectations.
module tb_timer_unit;

  localparam logic [31:0] A_TIM = 32'hFFFF_F020;
  localparam logic [31:0] A_FRE = 32'hFFFF_F024;
  localparam logic [31:0] A_OTH = 32'hFFFF_F028;

  logic        clk;
  logic        rst;
  logic [31:0] addr;
  logic        wen;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        tick;
  logic        ovf;

  int tests;
  int fails;
  bit started;

  timer_unit #(.ADDR_TIM(A_TIM), .ADDR_FRE(A_FRE)) dut (
    .clk  (clk),
    .rst  (rst),
    .addr (addr),
    .wen  (wen),
    .wdata(wdata),
    .rdata(rdata),
    .tick (tick),
    .ovf  (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: increments fall on whole multiples of the divider,
  // counted in cycles since the most recent FRE write.
  longint      cyc;
  longint      m_wcyc;
  logic [31:0] m_freq;
  logic [31:0] m_count;
  logic        m_tick;
  logic        m_ovf;

  initial begin
    cyc = 0; m_wcyc = 0; m_freq = 0; m_count = 0; m_tick = 0; m_ovf = 0;
  end

  always @(posedge clk) begin
    logic wt, wf, inc;
    cyc = cyc + 1;
    if (!rst) begin
      m_freq = 0; m_count = 0; m_tick = 0; m_ovf = 0;
    end else begin
      wt  = wen && (addr == A_TIM);
      wf  = wen && (addr == A_FRE);
      inc = !wf && (m_freq != 0) && (((cyc - m_wcyc) % longint'(m_freq)) == 0);
      m_tick = inc && !wt;
      m_ovf  = m_tick && (m_count == 32'hFFFF_FFFF);
      if (wt) m_count = wdata;
      else if (inc) m_count = m_count + 32'h1;
      if (wf) begin
        m_freq = wdata;
        m_wcyc = cyc;
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    logic [31:0] er;
    if (started) begin
      er = (addr == A_TIM) ? m_count : ((addr == A_FRE) ? m_freq : 32'h0);
      chk("model_rdata", rdata, er);
      chk("model_tick", {31'h0, tick}, {31'h0, m_tick});
      chk("model_ovf", {31'h0, ovf}, {31'h0, m_ovf});
    end
  end

  // Apply one bus cycle; returns just after the sampling edge.
  task automatic drive(input logic [31:0] a, input logic w, input logic [31:0] d);
    addr = a; wen = w; wdata = d;
    @(posedge clk);
    #1;
    wen = 1'b0;
  endtask

  task automatic rd(input string name, input logic [31:0] a, input logic [31:0] exp);
    addr = a; wen = 1'b0;
    #1;
    chk(name, rdata, exp);
  endtask

  task automatic flags(input string name, input logic et, input logic eo);
    chk({name, "_tick"}, {31'h0, tick}, {31'h0, et});
    chk({name, "_ovf"}, {31'h0, ovf}, {31'h0, eo});
  endtask

  initial begin
    tests = 0; fails = 0; started = 0;
    rst = 1'b0; addr = 32'h0; wen = 1'b0; wdata = 32'h0;

    // Reset defaults
    drive(A_TIM, 1'b0, 32'h0);
    started = 1;
    drive(A_TIM, 1'b0, 32'h0);
    rst = 1'b1;
    rd("rst_tim", A_TIM, 32'h0);
    rd("rst_fre", A_FRE, 32'h0);
    flags("rst", 1'b0, 1'b0);
    for (int i = 0; i < 20; i++) drive(A_TIM, 1'b0, 32'h0);
    rd("idle_tim", A_TIM, 32'h0);
    flags("idle", 1'b0, 1'b0);

    // Basic divide by 4
    drive(A_FRE, 1'b1, 32'd4);
    rd("div_fre", A_FRE, 32'd4);
    for (int i = 1; i <= 13; i++) begin
      drive(A_TIM, 1'b0, 32'h0);
      rd("div_tim", A_TIM, 32'(i / 4));
      flags("div", (i % 4) == 0, 1'b0);
    end

    // Wrap-around
    drive(A_TIM, 1'b1, 32'hFFFF_FFFE);
    drive(A_FRE, 1'b1, 32'd1);
    rd("wrap_start", A_TIM, 32'hFFFF_FFFE);
    flags("wrap_start", 1'b0, 1'b0);
    drive(A_TIM, 1'b0, 32'h0);
    rd("wrap_1", A_TIM, 32'hFFFF_FFFF);
    flags("wrap_1", 1'b1, 1'b0);
    drive(A_TIM, 1'b0, 32'h0);
    rd("wrap_2", A_TIM, 32'h0);
    flags("wrap_2", 1'b1, 1'b1);
    drive(A_TIM, 1'b0, 32'h0);
    rd("wrap_3", A_TIM, 32'h1);
    flags("wrap_3", 1'b1, 1'b0);

    // Simultaneous TIM write and increment (FRE = 2)
    drive(A_FRE, 1'b1, 32'd2);
    drive(A_TIM, 1'b0, 32'h0);
    drive(A_TIM, 1'b1, 32'h100);
    rd("sim_wr", A_TIM, 32'h100);
    flags("sim_wr", 1'b0, 1'b0);
    drive(A_TIM, 1'b0, 32'h0);
    rd("sim_e3", A_TIM, 32'h100);
    flags("sim_e3", 1'b0, 1'b0);
    drive(A_TIM, 1'b0, 32'h0);
    rd("sim_e4", A_TIM, 32'h101);
    flags("sim_e4", 1'b1, 1'b0);

    // Divider change mid-period
    drive(A_FRE, 1'b1, 32'd10);
    for (int i = 0; i < 7; i++) drive(A_TIM, 1'b0, 32'h0);
    rd("chg_pre7", A_TIM, 32'h101);
    drive(A_FRE, 1'b1, 32'd3);
    drive(A_TIM, 1'b0, 32'h0);
    rd("chg_w1", A_TIM, 32'h101);
    drive(A_TIM, 1'b0, 32'h0);
    rd("chg_w2", A_TIM, 32'h101);
    flags("chg_w2", 1'b0, 1'b0);
    drive(A_TIM, 1'b0, 32'h0);
    rd("chg_w3", A_TIM, 32'h102);
    flags("chg_w3", 1'b1, 1'b0);
    drive(A_FRE, 1'b1, 32'd0);
    for (int i = 0; i < 5; i++) drive(A_TIM, 1'b0, 32'h0);
    rd("stop_tim", A_TIM, 32'h102);
    flags("stop", 1'b0, 1'b0);

    // Reset mid-operation with a simultaneous TIM write
    drive(A_TIM, 1'b1, 32'd55);
    drive(A_FRE, 1'b1, 32'd1);
    rd("run_55", A_TIM, 32'd55);
    drive(A_TIM, 1'b0, 32'h0);
    drive(A_TIM, 1'b0, 32'h0);
    rd("run_57", A_TIM, 32'd57);
    rst = 1'b0;
    drive(A_TIM, 1'b1, 32'd9);
    rst = 1'b1;
    rd("mid_rst_tim", A_TIM, 32'h0);
    rd("mid_rst_fre", A_FRE, 32'h0);
    flags("mid_rst", 1'b0, 1'b0);
    rd("decode_oth", A_OTH, 32'h0);

    // Write to an unmapped address is ignored
    drive(A_FRE, 1'b1, 32'd1);
    drive(A_OTH, 1'b1, 32'hDEAD);
    rd("oth_tim", A_TIM, 32'h1);
    rd("oth_fre", A_FRE, 32'h1);
    rd("oth_rd", A_OTH, 32'h0);
    drive(A_TIM, 1'b0, 32'h0);
    rd("oth_tim2", A_TIM, 32'h2);

    started = 0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
